// File: rtl/ascon_io_pkg.sv
// Shared types and constants for the masked Ascon serial I/O front end.
package ascon_io_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StUnload
  } state_e;

  localparam int unsigned NonceLen  = 128;
  localparam int unsigned TagLen    = 128;
  localparam int unsigned DefKeyLen = 128;
  localparam int unsigned DefAdLen  = 40;
  localparam int unsigned DefCtLen  = 80;

  function automatic int unsigned max2(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/share_shift_reg.sv
// Per-share MSB-first shift register with parallel load; SHARES lanes of W bits.
module share_shift_reg #(
  parameter int unsigned LEN    = 8,
  parameter int unsigned SHARES = 1,
  parameter int unsigned W      = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    shift_en_i,
  input  logic                    load_en_i,
  input  logic [SHARES*W-1:0]     lane_i,
  input  logic [SHARES*LEN-1:0]   load_data_i,
  output logic [SHARES*W-1:0]     lane_o,
  output logic [SHARES*LEN-1:0]   data_o
);

  logic [SHARES*LEN-1:0] data_d, data_q;
  logic [LEN+W-1:0]      cat;

  always_comb begin
    data_d = data_q;
    cat    = '0;
    if (load_en_i) begin
      data_d = load_data_i;
    end else if (shift_en_i) begin
      for (int unsigned s = 0; s < SHARES; s++) begin
        // Concatenate then keep the low LEN bits, which also covers LEN == W.
        cat                    = {data_q[s*LEN +: LEN], lane_i[s*W +: W]};
        data_d[s*LEN +: LEN]   = cat[LEN-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  for (genvar s = 0; s < SHARES; s++) begin : g_lane
    assign lane_o[s*W +: W] = data_q[s*LEN + LEN - W +: W];
  end

  assign data_o = data_q;

endmodule

// File: rtl/ascon_share_io.sv
// Serial load / parallel capture / serial unload front end for the masked Ascon
// decryption core, with a saturating core-latency counter.
module ascon_share_io
  import ascon_io_pkg::*;
#(
  parameter int unsigned K      = DefKeyLen,
  parameter int unsigned L      = DefAdLen,
  parameter int unsigned Y      = DefCtLen,
  parameter int unsigned SHARES = 3,
  parameter int unsigned W      = 1,
  parameter int unsigned LATW   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SHARES*W-1:0]        key_in,
  input  logic [SHARES*W-1:0]        nonce_in,
  input  logic [SHARES*W-1:0]        ad_in,
  input  logic [SHARES*W-1:0]        ct_in,
  output logic [SHARES*K-1:0]        key_sh,
  output logic [SHARES*NonceLen-1:0] nonce_sh,
  output logic [SHARES*L-1:0]        ad_sh,
  output logic [SHARES*Y-1:0]        ct_sh,
  output logic                       core_start,
  input  logic                       core_ready,
  input  logic [SHARES*Y-1:0]        core_pt,
  input  logic [SHARES*TagLen-1:0]   core_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SHARES*W-1:0]        pt_out,
  output logic [SHARES*W-1:0]        tag_out,
  output logic                       done,
  output logic [LATW-1:0]            lat_cycles
);

  if ((W == 0) || (K % W != 0) || (L % W != 0) || (Y % W != 0) || (128 % W != 0))
  begin : g_bad_w
    $error("ascon_share_io: W must divide K, L, Y and 128");
  end
  if (SHARES < 1) begin : g_bad_shares
    $error("ascon_share_io: SHARES must be at least 1");
  end

  localparam int unsigned MaxIn   = max2(max2(K, NonceLen), max2(L, Y)) / W;
  localparam int unsigned MaxOut  = max2(Y, TagLen) / W;
  localparam int unsigned MaxBeat = max2(MaxIn, MaxOut);
  localparam int unsigned BeatW   = $clog2(MaxBeat + 1);

  typedef logic [BeatW-1:0] beat_t;

  localparam beat_t BeatKey     = beat_t'(K / W);
  localparam beat_t BeatNonce   = beat_t'(NonceLen / W);
  localparam beat_t BeatAd      = beat_t'(L / W);
  localparam beat_t BeatCt      = beat_t'(Y / W);
  localparam beat_t BeatPt      = beat_t'(Y / W);
  localparam beat_t BeatTag     = beat_t'(TagLen / W);
  localparam beat_t LastInBeat  = beat_t'(MaxIn - 1);
  localparam beat_t LastOutBeat = beat_t'(MaxOut - 1);

  state_e          state_d, state_q;
  beat_t           beat_d, beat_q;
  logic [LATW-1:0] lat_d, lat_q;
  logic            done_d, done_q;

  logic in_fire, out_fire, last_in, last_out, capture;
  logic key_shift, nonce_shift, ad_shift, ct_shift, pt_shift, tag_shift;

  logic [SHARES*W-1:0]        key_lane_unused, nonce_lane_unused;
  logic [SHARES*W-1:0]        ad_lane_unused, ct_lane_unused;
  logic [SHARES*Y-1:0]        pt_data_unused;
  logic [SHARES*TagLen-1:0]   tag_data_unused;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_in  = (beat_q == LastInBeat);
  assign last_out = (beat_q == LastOutBeat);
  assign capture  = (state_q == StWait) && core_ready;

  // Registers shorter than the longest field stop after their own beat count.
  assign key_shift   = in_fire && (beat_q < BeatKey);
  assign nonce_shift = in_fire && (beat_q < BeatNonce);
  assign ad_shift    = in_fire && (beat_q < BeatAd);
  assign ct_shift    = in_fire && (beat_q < BeatCt);
  assign pt_shift    = out_fire && (beat_q < BeatPt);
  assign tag_shift   = out_fire && (beat_q < BeatTag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        beat_d = '0;
        if (start) state_d = StLoad;
      end
      StLoad: begin
        if (in_fire) begin
          if (last_in) begin
            state_d = StStart;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StStart: begin
        lat_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (lat_q != {LATW{1'b1}}) lat_d = lat_q + 1'b1;
        beat_d = '0;
        if (core_ready) state_d = StUnload;
      end
      StUnload: begin
        if (out_fire) begin
          if (last_out) begin
            state_d = StIdle;
            beat_d  = '0;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      StLoad:   in_ready   = 1'b1;
      StStart:  core_start = 1'b1;
      StUnload: out_valid  = 1'b1;
      default:  ;
    endcase
  end

  assign done       = done_q;
  assign lat_cycles = lat_q;

  share_shift_reg #(.LEN(K), .SHARES(SHARES), .W(W)) u_key (
    .clk_i       (clk),
    .rst_i       (rst),
    .shift_en_i  (key_shift),
    .load_en_i   (1'b0),
    .lane_i      (key_in),
    .load_data_i ('0),
    .lane_o      (key_lane_unused),
    .data_o      (key_sh)
  );

  share_shift_reg #(.LEN(NonceLen), .SHARES(SHARES), .W(W)) u_nonce (
    .clk_i       (clk),
    .rst_i       (rst),
    .shift_en_i  (nonce_shift),
    .load_en_i   (1'b0),
    .lane_i      (nonce_in),
    .load_data_i ('0),
    .lane_o      (nonce_lane_unused),
    .data_o      (nonce_sh)
  );

  share_shift_reg #(.LEN(L), .SHARES(SHARES), .W(W)) u_ad (
    .clk_i       (clk),
    .rst_i       (rst),
    .shift_en_i  (ad_shift),
    .load_en_i   (1'b0),
    .lane_i      (ad_in),
    .load_data_i ('0),
    .lane_o      (ad_lane_unused),
    .data_o      (ad_sh)
  );

  share_shift_reg #(.LEN(Y), .SHARES(SHARES), .W(W)) u_ct (
    .clk_i       (clk),
    .rst_i       (rst),
    .shift_en_i  (ct_shift),
    .load_en_i   (1'b0),
    .lane_i      (ct_in),
    .load_data_i ('0),
    .lane_o      (ct_lane_unused),
    .data_o      (ct_sh)
  );

  // Output registers shift in zeros, so exhausted lanes read 0.
  share_shift_reg #(.LEN(Y), .SHARES(SHARES), .W(W)) u_pt (
    .clk_i       (clk),
    .rst_i       (rst),
    .shift_en_i  (pt_shift),
    .load_en_i   (capture),
    .lane_i      ('0),
    .load_data_i (core_pt),
    .lane_o      (pt_out),
    .data_o      (pt_data_unused)
  );

  share_shift_reg #(.LEN(TagLen), .SHARES(SHARES), .W(W)) u_tag (
    .clk_i       (clk),
    .rst_i       (rst),
    .shift_en_i  (tag_shift),
    .load_en_i   (capture),
    .lane_i      ('0),
    .load_data_i (core_tag),
    .lane_o      (tag_out),
    .data_o      (tag_data_unused)
  );

endmodule

// File: doc/ascon_share_io.md
Name: ascon_share_io

Overview:
- Parametrised serial I/O front end for the masked Ascon decryption core.
- Deserialises SHARES-way shared key, nonce, associated data and ciphertext at W bits per share per beat, under a valid/ready handshake.
- Starts the core, captures its shared plaintext and tag in parallel, then serialises them out under a valid/ready handshake.
- Reports core latency in clock cycles; replaces fixed 1-bit, fixed-3-share, free-running serial loading.

Parameters:
K, 128, key length in bits
L, 40, associated data length in bits
Y, 80, ciphertext/plaintext length in bits
SHARES, 3, number of Boolean shares per bit (>=1)
W, 1, bits per share per beat; must divide K, L, Y and 128 (elaboration error otherwise)
LATW, 16, width of latency counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a new transaction (sampled in IDLE only)
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&&in_ready
key_in  in  SHARES*W  key bits, share s at [s*W+:W]
nonce_in  in  SHARES*W  nonce bits
ad_in  in  SHARES*W  associated data bits
ct_in  in  SHARES*W  ciphertext bits
key_sh  out  SHARES*K  loaded key shares to core
nonce_sh  out  SHARES*128  loaded nonce shares
ad_sh  out  SHARES*L  loaded AD shares
ct_sh  out  SHARES*Y  loaded CT shares
core_start  out  1  one-cycle start pulse to core
core_ready  in  1  core done; pt/tag valid this cycle
core_pt  in  SHARES*Y  core plaintext shares
core_tag  in  SHARES*128  core tag shares
out_valid  out  1  output beat valid
out_ready  in  1  output beat consumed when out_valid&&out_ready
pt_out  out  SHARES*W  plaintext bits
tag_out  out  SHARES*W  tag bits
done  out  1  one-cycle pulse after last output beat
lat_cycles  out  LATW  cycles from core_start to core_ready, saturating

Behaviour:
- Reset: state IDLE. All outputs 0, including in_ready, core_start, out_valid, done, lat_cycles and all *_sh registers.
- MAXIN = max(K,128,L,Y)/W beats; MAXOUT = max(Y,128)/W beats. Beat counters are sized for these values.
- IDLE: start=1 -> LOAD (beat=0). start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - On each accepted beat i, every register whose length/W > i shifts left by W per share, new bits entering at the LSB (MSB-first order).
  - Registers already full hold their value; bits on their ports are ignored.
  - After beat MAXIN-1 is accepted -> START. in_ready drops the next cycle.
  - in_valid=0 stalls with no state change.
- START: core_start=1 for exactly one cycle, lat_cycles cleared to 0 -> WAIT.
- WAIT:
  - lat_cycles increments every cycle, saturating at 2^LATW-1.
  - core_ready=1: capture core_pt and core_tag into internal shift registers -> UNLOAD (beat=0).
  - core_ready is ignored outside WAIT.
  - If core_ready is high in the first WAIT cycle, lat_cycles=1.
- UNLOAD:
  - out_valid=1. pt_out/tag_out present the top W bits per share of the PT and tag shift registers.
  - On each accepted beat, a register shifts left only while beat < its length/W. After that its output lanes read 0.
  - After beat MAXOUT-1 is accepted -> IDLE with done=1 for one cycle.
  - out_ready=0 holds data and out_valid stable.
- *_sh outputs and lat_cycles hold their values until the next LOAD/START. The *_sh registers are not cleared on entering LOAD; they are fully overwritten by the load.
- rst in any state returns everything to reset values on the next edge; any in-flight transaction is dropped.
- start and in_valid in the same cycle in IDLE: start is taken; in_valid is ignored because in_ready=0.

Decomposition:
- Package ascon_io_pkg holds:
  - the state enum: IDLE, LOAD, START, WAIT, UNLOAD;
  - the default lengths (128 nonce/tag width);
  - the max() constant function used for MAXIN/MAXOUT.
- One sub-module, share_shift_reg (params LEN, SHARES, W, with in/out lanes, shift enable and parallel load).
  - Instantiated four times for input and twice for output.

Test Plan:
1. SHARES=3, W=1, K=128, L=40, Y=80; KEY=2db083053e848cefa30007336c47a5a1, NONCE=3f3607dbce3503ba84f5843d623de056, AD=4153434f4e, CT=87a59a2ea49b233259e3, random masks; 128 beats -> XOR of the 3 key_sh shares = KEY, and likewise for nonce/ad/ct; core_start pulses once, 1 cycle after the last beat.
2. Core model raises core_ready 37 cycles after core_start with known PT/tag shares -> lat_cycles=37; 128 output beats; reassembled PT (80 bits) and tag (128 bits) match the model; done pulses once; bits beyond beat 79 on pt_out lanes are 0.
3. W=8, SHARES=2, same vectors -> 16 input and 16 output beats; results identical to scenario 1 after unmasking.
4. Random in_valid/out_ready gaps (50%) -> data identical to the gap-free run; no beat lost or duplicated; out_valid never drops without an accepted beat.
5. rst asserted mid-LOAD (beat 60), and separately mid-UNLOAD -> next cycle all outputs 0 and state IDLE; a following full transaction is correct.
6. core_ready pulsed in IDLE/LOAD, and start pulsed during WAIT -> both ignored; a core_ready held low for 2^LATW+5 cycles -> lat_cycles saturates at 65535.
